parking_gate_sensor: RTL
========================

# parking_gate_sensor

Upstream front-end for the parking occupancy counter. It takes the two raw beam-break sensors of a single gate lane, synchronises and debounces them, and tracks the beam sequence with a direction FSM. It emits one-cycle `car_enter` / `car_exit` pulses that drive the counter's increment/decrement inputs directly. Aborted passes, illegal sensor patterns and stalled passes never produce a count pulse.

## Interface
- `DEBOUNCE_CYCLES`, 4: consecutive stable cycles required before a debounced sensor level changes (≥1).
- `TIMEOUT_CYCLES`, 1000: maximum cycles the FSM may remain in one pass state before a fault (≥2).
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high.
- `sensor_a` in 1: raw outer beam, 1 = blocked; asynchronous to `clk`.
- `sensor_b` in 1: raw inner beam, 1 = blocked; asynchronous to `clk`.
- `car_enter` out 1: registered one-cycle pulse on a completed inbound pass.
- `car_exit` out 1: registered one-cycle pulse on a completed outbound pass.
- `fault` out 1: registered one-cycle pulse on an illegal transition or timeout.
- `busy` out 1: registered; high whenever the FSM is not in IDLE.
- `abort_count` out 8: saturating count of backed-out passes. Present only with `PARKING_GATE_STATS_EN`.
- `fault_count` out 8: saturating count of `fault` pulses. Present only with `PARKING_GATE_STATS_EN`.

## Operation
- Input path: 2-flop synchroniser per sensor, then a per-sensor debouncer.
  - Debounced level takes the synced value after it differs from the current debounced level for `DEBOUNCE_CYCLES` consecutive cycles.
  - Any agreeing sample clears that sensor's debounce counter.
- FSM input is the debounced pair {a,b}. Transitions per state:
  - IDLE: 10→E1; 01→X1; 11→fault, WAIT_CLEAR; 00 stays.
  - E1 (10): 11→E2; 00→IDLE (abort); 01→fault.
  - E2 (11): 01→E3; 10→E1; 00→fault.
  - E3 (01): 00→IDLE with `car_enter`; 11→E2; 10→fault.
  - X1 (01): 11→X2; 00→IDLE (abort); 10→fault.
  - X2 (11): 10→X3; 01→X1; 00→fault.
  - X3 (10): 00→IDLE with `car_exit`; 11→X2; 01→fault.
  - Every "fault" above means: pulse `fault`, go to WAIT_CLEAR.
  - WAIT_CLEAR: stays until debounced 00, then IDLE. No timeout in this state.
- Timeout:
  - Dwell counter of width `$clog2(TIMEOUT_CYCLES+1)`; cleared on every state change.
  - Increments only while in E1–E3 or X1–X3.
  - Reaching `TIMEOUT_CYCLES` pulses `fault` and forces WAIT_CLEAR.
- `car_enter` and `car_exit` are mutually exclusive by construction and are never asserted together with `fault`.
- Reset mid-pass: state returns to IDLE, all sync/debounce flops clear to 0, and no pulse is emitted for the interrupted pass.

## Timing
- Reset values: `car_enter`=0, `car_exit`=0, `fault`=0, `busy`=0. With the macro, `abort_count`=0 and `fault_count`=0.
- Latency from a raw sensor edge (first sampling clock edge) to the FSM reaction or output pulse is 2 + `DEBOUNCE_CYCLES` + 1 rising edges (7 at defaults).
- Each pulse is high for exactly one cycle per qualifying transition.
- `busy` rises in the same cycle as the first state output leaving IDLE and falls in the same cycle as the `car_enter`/`car_exit` pulse.
- Minimum hold per sensor level for recognition is `DEBOUNCE_CYCLES` cycles after synchronisation. Shorter glitches are invisible.

## Configuration
- `PARKING_GATE_STATS_EN` defined:
  - Adds `abort_count` and `fault_count`.
  - `abort_count` increments on each E1→IDLE or X1→IDLE abort.
  - `fault_count` increments on each `fault` pulse.
  - Both saturate at 255 and hold; only `reset` clears them.
- Undefined: both ports and their logic are absent; all other behaviour is identical.

## Test plan
- Defaults; drive 00→10→11→01→00, each level held 10 cycles → exactly one `car_enter` pulse, 7 edges after the final raw edge; `car_exit`=0, `fault`=0.
- Drive 00→01→11→10→00, 10 cycles each → exactly one `car_exit` pulse; `busy` falls on the same cycle.
- `sensor_a` high for 3 cycles, then low → `busy` stays 0 and no pulses occur. Repeat with 10 cycles high then low → no pulse, `abort_count`=1.
- Both sensors rise on the same edge, held 20 cycles → one `fault` pulse. A following full enter sequence started before 00 yields no `car_enter`. After 00 the next full sequence produces `car_enter`.
- `TIMEOUT_CYCLES`=64; hold 10 for 100 cycles → `fault` once, 64 cycles after E1 entry. Subsequent 11/01 changes are ignored until 00.
- Assert `reset` while in E2 → all outputs 0 immediately. Release with sensors at 00 → no pulse; a fresh enter sequence counts normally. With the macro, drive 300 aborts → `abort_count` holds at 255.

Source files
------------

// File: rtl/parking_gate_sensor.sv
// parking_gate_sensor: beam-break front end for one gate lane.
// Synchronises and debounces the outer (a) and inner (b) beams, then tracks
// the beam sequence to emit one-cycle car_enter / car_exit / fault pulses.
// Optional statistics counters are enabled by defining PARKING_GATE_STATS_EN.
module parking_gate_sensor #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sensor_a,
  input  logic       sensor_b,
  output logic       car_enter,
  output logic       car_exit,
  output logic       fault,
  output logic       busy
`ifdef PARKING_GATE_STATS_EN
  ,
  output logic [7:0] abort_count,
  output logic [7:0] fault_count
`endif
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE,
    E1,
    E2,
    E3,
    X1,
    X2,
    X3,
    WAIT_CLEAR
  } state_t;

  // Bit 1 carries beam a, bit 0 carries beam b, so {a,b} patterns read directly.
  logic [1:0]         sync1;
  logic [1:0]         sync2;
  logic [1:0]         deb;
  logic [1:0][DW-1:0] deb_cnt;

  state_t             state;
  state_t             state_nxt;
  logic [TW-1:0]      dwell;
  logic [TW-1:0]      dwell_nxt;
  logic               in_pass;
  logic               enter_nxt;
  logic               exit_nxt;
  logic               fault_nxt;

  // Two-flop synchroniser for both raw beams.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {sensor_a, sensor_b};
      sync2 <= sync1;
    end
  end

  // Per-beam debouncer: adopt the synced level after DEBOUNCE_CYCLES
  // consecutive disagreeing samples; any agreeing sample restarts the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deb     <= '0;
      deb_cnt <= '0;
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (sync2[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          deb[i]     <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DW'(1);
        end
      end
    end
  end

  // Direction FSM next-state, pulse decode and dwell timeout.
  always_comb begin
    state_nxt = state;
    enter_nxt = 1'b0;
    exit_nxt  = 1'b0;
    fault_nxt = 1'b0;
    in_pass   = state inside {E1, E2, E3, X1, X2, X3};

    case (state)
      IDLE: begin
        case (deb)
          2'b10:   state_nxt = E1;
          2'b01:   state_nxt = X1;
          2'b11:   begin state_nxt = WAIT_CLEAR; fault_nxt = 1'b1; end
          default: state_nxt = IDLE;
        endcase
      end
      E1: begin
        case (deb)
          2'b11:   state_nxt = E2;
          2'b00:   state_nxt = IDLE;
          2'b01:   begin state_nxt = WAIT_CLEAR; fault_nxt = 1'b1; end
          default: state_nxt = E1;
        endcase
      end
      E2: begin
        case (deb)
          2'b01:   state_nxt = E3;
          2'b10:   state_nxt = E1;
          2'b00:   begin state_nxt = WAIT_CLEAR; fault_nxt = 1'b1; end
          default: state_nxt = E2;
        endcase
      end
      E3: begin
        case (deb)
          2'b00:   begin state_nxt = IDLE; enter_nxt = 1'b1; end
          2'b11:   state_nxt = E2;
          2'b10:   begin state_nxt = WAIT_CLEAR; fault_nxt = 1'b1; end
          default: state_nxt = E3;
        endcase
      end
      X1: begin
        case (deb)
          2'b11:   state_nxt = X2;
          2'b00:   state_nxt = IDLE;
          2'b10:   begin state_nxt = WAIT_CLEAR; fault_nxt = 1'b1; end
          default: state_nxt = X1;
        endcase
      end
      X2: begin
        case (deb)
          2'b10:   state_nxt = X3;
          2'b01:   state_nxt = X1;
          2'b00:   begin state_nxt = WAIT_CLEAR; fault_nxt = 1'b1; end
          default: state_nxt = X2;
        endcase
      end
      X3: begin
        case (deb)
          2'b00:   begin state_nxt = IDLE; exit_nxt = 1'b1; end
          2'b11:   state_nxt = X2;
          2'b01:   begin state_nxt = WAIT_CLEAR; fault_nxt = 1'b1; end
          default: state_nxt = X3;
        endcase
      end
      WAIT_CLEAR: begin
        if (deb == 2'b00) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // A stalled pass overrides whatever the beams asked for this cycle.
    if (in_pass && (dwell == TW'(TIMEOUT_CYCLES - 1))) begin
      state_nxt = WAIT_CLEAR;
      enter_nxt = 1'b0;
      exit_nxt  = 1'b0;
      fault_nxt = 1'b1;
    end

    if (state_nxt != state) begin
      dwell_nxt = '0;
    end else if (in_pass) begin
      dwell_nxt = dwell + TW'(1);
    end else begin
      dwell_nxt = '0;
    end
  end

  // FSM state, dwell counter and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      dwell     <= '0;
      car_enter <= 1'b0;
      car_exit  <= 1'b0;
      fault     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      dwell     <= dwell_nxt;
      car_enter <= enter_nxt;
      car_exit  <= exit_nxt;
      fault     <= fault_nxt;
      busy      <= (state_nxt != IDLE);
    end
  end

`ifdef PARKING_GATE_STATS_EN
  // E1/X1 can only reach IDLE by backing out; timeouts go to WAIT_CLEAR.
  logic abort_evt;
  assign abort_evt = (state inside {E1, X1}) && (state_nxt == IDLE);

  // Saturating abort and fault statistics.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      abort_count <= '0;
      fault_count <= '0;
    end else begin
      if (abort_evt && (abort_count != '1)) begin
        abort_count <= abort_count + 8'd1;
      end
      if (fault_nxt && (fault_count != '1)) begin
        fault_count <= fault_count + 8'd1;
      end
    end
  end
`endif

endmodule
